hazard_unit: RTL

Pipeline control stage for the 5-stage RV32I core. Arbitrates icache/dcache stalls, load-use hazards and EX-stage redirects, and drives the `pipe_ctrl_struct` load enables consumed by the IF/ID, ID/EX, EX/MEM and MEM/WB registers. Holds a cache's response when that cache completes before the other, so the pipeline advances exactly once per instruction with no re-issued requests.

---
 rtl/hazard_unit_pkg.sv | 43 ++++
 rtl/hazard_unit_if.sv | 29 ++
 rtl/hazard_unit_resp_hold.sv | 40 ++++
 rtl/hazard_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/hazard_unit_pkg.sv
// hazard_unit_pkg
//   Shared types for the pipeline hazard/stall controller.
//   - hazard_state_t   : cache-completion tracking FSM states
//   - pipe_ctrl_struct : load enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers
//   - load_use_hit()   : detects a load in EX whose result the ID instruction needs
package hazard_unit_pkg;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    I_HELD = 2'd1,
    D_HELD = 2'd2
  } hazard_state_t;

  typedef struct packed {
    logic ifid_ld;
    logic idex_ld;
    logic exmem_ld;
    logic memwb_ld;
  } pipe_ctrl_struct;

  localparam pipe_ctrl_struct PIPE_NONE = '{ifid_ld: 1'b0, idex_ld: 1'b0, exmem_ld: 1'b0, memwb_ld: 1'b0};
  localparam pipe_ctrl_struct PIPE_ALL  = '{ifid_ld: 1'b1, idex_ld: 1'b1, exmem_ld: 1'b1, memwb_ld: 1'b1};

  // x0 never carries a real dependency, so a load targeting it can't cause a hazard.
  function automatic logic load_use_hit(
    input logic             ex_is_load,
    input logic [REG_W-1:0] ex_rd,
    input logic             uses_rs1,
    input logic [REG_W-1:0] rs1,
    input logic             uses_rs2,
    input logic [REG_W-1:0] rs2
  );
    logic match1;
    logic match2;
    match1 = uses_rs1 && (rs1 == ex_rd);
    match2 = uses_rs2 && (rs2 == ex_rd);
    return ex_is_load && (ex_rd != '0) && (match1 || match2);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// hazard_unit_if
//   Cache handshake bundle between the caches/EX-MEM stage and the hazard unit.
//   icache_resp/icache_rdata : icache completion and data
//   dcache_req               : EX/MEM wants a dcache access this cycle
//   dcache_resp/dcache_rdata : dcache completion and data
//   icache_read/dcache_en    : request enables back to the caches
//   Modports: master = cache side, slave = hazard unit.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic            icache_resp;
  logic [XLEN-1:0] icache_rdata;
  logic            icache_read;
  logic            dcache_req;
  logic            dcache_resp;
  logic [XLEN-1:0] dcache_rdata;
  logic            dcache_en;

  modport master (
    output icache_resp, icache_rdata, dcache_req, dcache_resp, dcache_rdata,
    input  icache_read, dcache_en
  );

  modport slave (
    input  icache_resp, icache_rdata, dcache_req, dcache_resp, dcache_rdata,
    output icache_read, dcache_en
  );

endinterface

// File: rtl/hazard_unit_resp_hold.sv
// resp_hold
//   Holds one cache's read data when that cache completes before the other,
//   so the pipeline sees the same word on the edge it finally advances.
//   Ports:
//     clk, rst      : clock, synchronous active-high reset
//     resp, rdata   : cache completion and read data
//     capture       : the controller is entering the held state for this cache
//     release_en    : the pipeline advances this cycle, held word is consumed
//     held          : a word is being held
//     data          : held word while held, otherwise the live rdata
module resp_hold
  import hazard_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            resp,
  input  logic [XLEN-1:0] rdata,
  input  logic            capture,
  input  logic            release_en,
  output logic            held,
  output logic [XLEN-1:0] data
);

  logic [XLEN-1:0] hold_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      held   <= 1'b0;
      hold_q <= '0;
    end else if (capture && resp) begin
      held   <= 1'b1;
      hold_q <= rdata;
    end else if (release_en) begin
      held   <= 1'b0;
    end
  end

  assign data = held ? hold_q : rdata;

endmodule

// File: rtl/hazard_unit.sv
// hazard_unit
//   Pipeline control for the 5-stage core: merges icache/dcache completion,
//   load-use hazards and EX redirects into per-register load enables.
//   Ports:
//     clk, rst              : clock, synchronous active-high reset
//     cache                 : cache handshake bundle (slave side)
//     id_rs1/id_rs2, id_uses_rs1/id_uses_rs2 : ID source operands
//     ex_rd, ex_is_load     : EX destination and load flag
//     ex_redirect           : EX resolved a taken branch/jump
//     pipe_ctrl, pc_ld      : register and PC load enables
//     ifid_flush/idex_flush : insert a bubble into IF/ID / ID/EX
//     instr_out/mem_rdata_out : instruction and load data into IF/ID and MEM/WB
//     stall_count           : saturating count of non-advancing cycles
//
//   state  | meaning
//   RUN    | nothing held; waiting on whichever cache is outstanding
//   I_HELD | icache done and held, dcache still pending
//   D_HELD | dcache done and held, icache still pending
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_unit_if.slave      cache,
  input  logic [REG_W-1:0]  id_rs1,
  input  logic [REG_W-1:0]  id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_is_load,
  input  logic              ex_redirect,
  output pipe_ctrl_struct   pipe_ctrl,
  output logic              pc_ld,
  output logic              ifid_flush,
  output logic              idex_flush,
  output logic [XLEN-1:0]   instr_out,
  output logic [XLEN-1:0]   mem_rdata_out,
  output logic [CNT_W-1:0]  stall_count
);

  hazard_state_t state;
  hazard_state_t state_n;

  logic i_ok;
  logic d_ok;
  logic adv;
  logic load_use;
  logic i_capture;
  logic d_capture;
  logic i_held;
  logic d_held;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    i_ok    = cache.icache_resp || (state == I_HELD);
    d_ok    = !cache.dcache_req || cache.dcache_resp || (state == D_HELD);
    adv     = i_ok && d_ok;
    state_n = state;
    if (adv) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (cache.icache_resp && !d_ok) begin
        state_n = I_HELD;
      end else if (cache.dcache_req && cache.dcache_resp && !cache.icache_resp) begin
        state_n = D_HELD;
      end
    end
  end

  assign i_capture = (state == RUN) && (state_n == I_HELD);
  assign d_capture = (state == RUN) && (state_n == D_HELD);

  // ------------------------------------------------------ response holds
  resp_hold u_ihold (
    .clk        (clk),
    .rst        (rst),
    .resp       (cache.icache_resp),
    .rdata      (cache.icache_rdata),
    .capture    (i_capture),
    .release_en (adv),
    .held       (i_held),
    .data       (instr_out)
  );

  resp_hold u_dhold (
    .clk        (clk),
    .rst        (rst),
    .resp       (cache.dcache_resp),
    .rdata      (cache.dcache_rdata),
    .capture    (d_capture),
    .release_en (adv),
    .held       (d_held),
    .data       (mem_rdata_out)
  );

  // A completed cache is never asked again until the pipeline moves on.
  assign cache.icache_read = !rst && !i_held;
  assign cache.dcache_en   = !rst && cache.dcache_req && !d_held;

  // ------------------------------------------------- hazard / load enables
  assign load_use = load_use_hit(ex_is_load, ex_rd, id_uses_rs1, id_rs1, id_uses_rs2, id_rs2);

  always_comb begin
    pipe_ctrl  = PIPE_NONE;
    pc_ld      = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (!rst && adv) begin
      if (ex_redirect) begin
        pipe_ctrl  = PIPE_ALL;
        pc_ld      = 1'b1;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use) begin
        // Freeze PC and IF/ID, push a bubble into EX, let older stages drain.
        pipe_ctrl         = PIPE_ALL;
        pipe_ctrl.ifid_ld = 1'b0;
        idex_flush        = 1'b1;
      end else begin
        pipe_ctrl = PIPE_ALL;
        pc_ld     = 1'b1;
      end
    end
  end

  // ------------------------------------------------------- stall counter
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
    end else if (!adv && (stall_count != '1)) begin
      stall_count <= stall_count + 1'b1;
    end
  end

endmodule
